// File: rtl/uart_char_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_char_tx
// Purpose  : Single-character UART transmitter. A character is accepted when
//            load=1 while ready=1, then sent as start bit (0), eight data
//            bits LSB first, optional even-parity bit and stop bit (1). Every
//            bit lasts CLKS_PER_BIT clk cycles. charSent pulses on the last
//            cycle of the stop bit and ready returns on the following cycle.
// Options  : define UART_CHAR_TX_PARITY_EN to insert an even-parity bit
//            between the data bits and the stop bit (11-bit frame instead
//            of 10-bit frame).
// Ports    : clk      - rising-edge clock
//            rst      - synchronous reset, active low
//            data_in  - character to send, sampled only on acceptance
//            load     - request to send data_in
//            ready    - high when a load will be accepted (IDLE only)
//            tx       - registered serial line, idle high
//            charSent - one-cycle pulse on the final cycle of a frame
// Revision : 1.0 - initial release
// ============================================================================
module uart_char_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       ready,
  output logic       tx,
  output logic       charSent
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] c_BIT_LAST   = BW'(CLKS_PER_BIT - 1);
  // charSent is registered, so it is raised one cycle before the stop bit ends
  localparam logic [BW-1:0] c_BIT_PENULT = BW'(CLKS_PER_BIT - 2);

`ifdef UART_CHAR_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t          r_state;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_ready;
  logic            r_charSent;
`ifdef UART_CHAR_TX_PARITY_EN
  logic            r_parity;
`endif

  logic            w_bit_end;

  assign w_bit_end = (r_baud == c_BIT_LAST);

  assign ready    = r_ready;
  assign tx       = r_tx;
  assign charSent = r_charSent;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b1;
      r_charSent <= 1'b0;
`ifdef UART_CHAR_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_charSent <= 1'b0;

      // Baud counter runs in every bit state and wraps to zero at the end of
      // each bit, so every new bit starts from a cleared count.
      if (r_state != S_IDLE) begin
        r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (load) begin
            r_shift <= data_in;
            r_baud  <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_state <= S_START;
`ifdef UART_CHAR_TX_PARITY_EN
            r_parity <= ^data_in;
`endif
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            if (r_idx == 3'd7) begin
`ifdef UART_CHAR_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              // r_shift[1] is the bit that sits in r_shift[0] after this shift
              r_idx   <= r_idx + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end
        end

`ifdef UART_CHAR_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (r_baud == c_BIT_PENULT) begin
            r_charSent <= 1'b1;
          end
          if (w_bit_end) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_baud  <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_char_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_char_tx
// Purpose  : Self-checking bench for uart_char_tx. Two instances are used:
//            CLKS_PER_BIT=4 for the main scenarios and CLKS_PER_BIT=2 for the
//            minimum-divider case. Expected characters are queued when a
//            load is driven and popped when the captured frame is checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_char_tx;

  localparam int CPB  = 4;
  localparam int CPB2 = 2;
`ifdef UART_CHAR_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F  = NB * CPB;
  localparam int F2 = NB * CPB2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din4, din2;
  logic       load4, load2;
  logic       ready4, tx4, cs4;
  logic       ready2, tx2, cs2;

  always #5 clk = ~clk;

  uart_char_tx #(.CLKS_PER_BIT(CPB)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .data_in (din4),
    .load    (load4),
    .ready   (ready4),
    .tx      (tx4),
    .charSent(cs4)
  );

  uart_char_tx #(.CLKS_PER_BIT(CPB2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .data_in (din2),
    .load    (load2),
    .ready   (ready2),
    .tx      (tx2),
    .charSent(cs2)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] sbq[$];

  logic cap_tx [1:255];
  logic cap_cs [1:255];
  logic cap_rdy[1:255];

  // Record n cycles of outputs, one sample per falling edge. Cycle 1 is the
  // cycle directly after the rising edge that accepted the load.
  task automatic capture(input bit sel, input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      cap_tx[c]  = sel ? tx2    : tx4;
      cap_cs[c]  = sel ? cs2    : cs4;
      cap_rdy[c] = sel ? ready2 : ready4;
    end
  endtask

  // Reference line level for cycle k (0-based) inside a frame of character d
  function automatic logic exp_tx(input logic [7:0] d, input int k, input int cpb);
    int b;
    b = k / cpb;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_CHAR_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst = 1'b0; load4 = 1'b1; load2 = 1'b1; din4 = 8'hFF; din2 = 8'hFF;
    repeat (2) @(negedge clk);
    total++; if (tx4 !== 1'b1)    begin bad++; $display("FAIL reset_tx4 got=%b want=1", tx4); end
    total++; if (ready4 !== 1'b1) begin bad++; $display("FAIL reset_ready4 got=%b want=1", ready4); end
    total++; if (cs4 !== 1'b0)    begin bad++; $display("FAIL reset_cs4 got=%b want=0", cs4); end
    total++; if (tx2 !== 1'b1)    begin bad++; $display("FAIL reset_tx2 got=%b want=1", tx2); end
    total++; if (ready2 !== 1'b1) begin bad++; $display("FAIL reset_ready2 got=%b want=1", ready2); end
    total++; if (cs2 !== 1'b0)    begin bad++; $display("FAIL reset_cs2 got=%b want=0", cs2); end
    load4 = 1'b0; load2 = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (tx4 !== 1'b1 || ready4 !== 1'b1)
      begin bad++; $display("FAIL idle_after_reset tx=%b ready=%b want 1,1", tx4, ready4); end
  endtask

  task automatic test_frame(input logic [7:0] d);
    logic [7:0] want, got;
    logic       okf;
    int         at;
    @(negedge clk); din4 = d; load4 = 1'b1; sbq.push_back(d);
    fork
      capture(1'b0, F + 2);
      begin @(negedge clk); load4 = 1'b0; din4 = ~d; end
    join
    want = sbq.pop_front();
    for (int i = 0; i < 8; i++) got[i] = cap_tx[1 + (i + 1) * CPB + CPB / 2];
    total++; if (got !== want) begin bad++; $display("FAIL frame_byte got=%h want=%h", got, want); end
    okf = 1'b1; at = 0;
    for (int c = 1; c <= F; c++)
      if (okf && cap_tx[c] !== exp_tx(want, c - 1, CPB)) begin okf = 1'b0; at = c; end
    total++; if (!okf) begin bad++; $display("FAIL frame_wave(%h) cycle=%0d got=%b want=%b", want, at, cap_tx[at], exp_tx(want, at - 1, CPB)); end
    okf = 1'b1; at = 0;
    for (int c = 1; c <= F + 2; c++)
      if (okf && cap_cs[c] !== (c == F)) begin okf = 1'b0; at = c; end
    total++; if (!okf) begin bad++; $display("FAIL frame_charSent cycle=%0d got=%b want=%b", at, cap_cs[at], (at == F)); end
    okf = 1'b1; at = 0;
    for (int c = 1; c <= F + 2; c++)
      if (okf && cap_rdy[c] !== (c > F)) begin okf = 1'b0; at = c; end
    total++; if (!okf) begin bad++; $display("FAIL frame_ready cycle=%0d got=%b want=%b", at, cap_rdy[at], (at > F)); end
  endtask

  task automatic test_ignore_load;
    logic [7:0] want;
    logic       okf;
    int         at;
    @(negedge clk); din4 = 8'h5A; load4 = 1'b1; sbq.push_back(8'h5A);
    fork
      capture(1'b0, F + 2 * CPB);
      begin
        @(negedge clk); load4 = 1'b0;
        repeat (9) @(negedge clk);
        din4 = 8'h00; load4 = 1'b1;
        @(negedge clk); load4 = 1'b0;
      end
    join
    want = sbq.pop_front();
    okf = 1'b1; at = 0;
    for (int c = 1; c <= F + 2 * CPB; c++)
      if (okf && cap_tx[c] !== ((c <= F) ? exp_tx(want, c - 1, CPB) : 1'b1)) begin okf = 1'b0; at = c; end
    total++; if (!okf) begin bad++; $display("FAIL ignore_load_wave cycle=%0d got=%b", at, cap_tx[at]); end
    okf = 1'b1; at = 0;
    for (int c = 1; c <= F + 2 * CPB; c++)
      if (okf && cap_rdy[c] !== (c > F)) begin okf = 1'b0; at = c; end
    total++; if (!okf) begin bad++; $display("FAIL ignore_load_ready cycle=%0d got=%b want=%b", at, cap_rdy[at], (at > F)); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] want1, want2, got;
    logic       okf;
    int         at;
    @(negedge clk); din4 = 8'h3C; load4 = 1'b1;
    sbq.push_back(8'h3C); sbq.push_back(8'hFF);
    fork
      capture(1'b0, 2 * F + 2);
      begin
        repeat (12) @(negedge clk);
        din4 = 8'hFF;
        repeat (F + 3 - 12) @(negedge clk);
        load4 = 1'b0;
      end
    join
    want1 = sbq.pop_front();
    want2 = sbq.pop_front();
    for (int i = 0; i < 8; i++) got[i] = cap_tx[1 + (i + 1) * CPB + CPB / 2];
    total++; if (got !== want1) begin bad++; $display("FAIL b2b_first got=%h want=%h", got, want1); end
    total++; if (cap_tx[F + 1] !== 1'b1 || cap_rdy[F + 1] !== 1'b1)
      begin bad++; $display("FAIL b2b_idle_gap tx=%b ready=%b want 1,1", cap_tx[F + 1], cap_rdy[F + 1]); end
    okf = 1'b1; at = 0;
    for (int c = F + 2; c <= 2 * F + 1; c++)
      if (okf && cap_tx[c] !== exp_tx(want2, c - F - 2, CPB)) begin okf = 1'b0; at = c; end
    total++; if (!okf) begin bad++; $display("FAIL b2b_second_wave cycle=%0d got=%b", at, cap_tx[at]); end
    okf = 1'b1; at = 0;
    for (int c = 1; c <= 2 * F + 2; c++)
      if (okf && cap_cs[c] !== (c == F || c == 2 * F + 1)) begin okf = 1'b0; at = c; end
    total++; if (!okf) begin bad++; $display("FAIL b2b_charSent cycle=%0d got=%b", at, cap_cs[at]); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] want;
    logic       okf;
    int         at;
    @(negedge clk); din4 = 8'h00; load4 = 1'b1; sbq.push_back(8'h00);
    fork
      capture(1'b0, 30);
      begin
        @(negedge clk); load4 = 1'b0;
        repeat (17) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
      end
    join
    want = sbq.pop_front();
    okf = 1'b1; at = 0;
    for (int c = 1; c <= 18; c++)
      if (okf && cap_tx[c] !== exp_tx(want, c - 1, CPB)) begin okf = 1'b0; at = c; end
    total++; if (!okf) begin bad++; $display("FAIL abort_pre_wave cycle=%0d got=%b", at, cap_tx[at]); end
    total++; if (cap_tx[19] !== 1'b1) begin bad++; $display("FAIL abort_tx got=%b want=1", cap_tx[19]); end
    okf = 1'b1; at = 0;
    for (int c = 19; c <= 30; c++)
      if (okf && (cap_tx[c] !== 1'b1 || cap_rdy[c] !== 1'b1)) begin okf = 1'b0; at = c; end
    total++; if (!okf) begin bad++; $display("FAIL abort_idle cycle=%0d tx=%b ready=%b", at, cap_tx[at], cap_rdy[at]); end
    okf = 1'b1; at = 0;
    for (int c = 1; c <= 30; c++)
      if (okf && cap_cs[c] !== 1'b0) begin okf = 1'b0; at = c; end
    total++; if (!okf) begin bad++; $display("FAIL abort_charSent cycle=%0d got=%b want=0", at, cap_cs[at]); end
  endtask

  task automatic test_min_divider;
    logic [7:0] want;
    logic       okf;
    int         at;
    @(negedge clk); din2 = 8'hFF; load2 = 1'b1; sbq.push_back(8'hFF);
    fork
      capture(1'b1, F2 + 2);
      begin @(negedge clk); load2 = 1'b0; end
    join
    want = sbq.pop_front();
    total++; if (cap_tx[1] !== 1'b0 || cap_tx[2] !== 1'b0 || cap_tx[3] !== 1'b1)
      begin bad++; $display("FAIL cpb2_start got=%b%b%b want=001", cap_tx[1], cap_tx[2], cap_tx[3]); end
    okf = 1'b1; at = 0;
    for (int c = 1; c <= F2 + 2; c++)
      if (okf && cap_tx[c] !== ((c <= F2) ? exp_tx(want, c - 1, CPB2) : 1'b1)) begin okf = 1'b0; at = c; end
    total++; if (!okf) begin bad++; $display("FAIL cpb2_wave cycle=%0d got=%b", at, cap_tx[at]); end
    okf = 1'b1; at = 0;
    for (int c = 1; c <= F2 + 2; c++)
      if (okf && (cap_cs[c] !== (c == F2) || cap_rdy[c] !== (c > F2))) begin okf = 1'b0; at = c; end
    total++; if (!okf) begin bad++; $display("FAIL cpb2_end cycle=%0d charSent=%b ready=%b", at, cap_cs[at], cap_rdy[at]); end
  endtask

  initial begin
    rst = 1'b0; load4 = 1'b0; load2 = 1'b0; din4 = 8'h00; din2 = 8'h00;
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h07);
    test_ignore_load();
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_reset_midframe();
    test_frame(8'h81);
    test_min_divider();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
